// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU operation codes, forwarding select
// encoding and architectural register constants.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_NOP = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_OR  = 4'b0010,
    ALU_ADD = 4'b0011,
    ALU_LUI = 4'b0100,
    ALU_SLL = 4'b0101
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forward_mux.sv
// RAW-hazard operand forwarding for one source register: picks the youngest
// in-flight result that targets the register, else the registered read data.
module forward_mux
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [4:0]            addr,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic                  exmem_reg_write,
  input  logic [4:0]            exmem_rd_addr,
  input  logic [DATA_WIDTH-1:0] exmem_data,
  input  logic                  memwb_reg_write,
  input  logic [4:0]            memwb_rd_addr,
  input  logic [DATA_WIDTH-1:0] memwb_data,
  output logic [DATA_WIDTH-1:0] data,
  output fwd_sel_e              sel
);

  logic exmem_hit;
  logic memwb_hit;

  // $zero is hard-wired, so a pending write to it must never be forwarded.
  assign exmem_hit = exmem_reg_write && (exmem_rd_addr == addr) && (addr != REG_ZERO);
  assign memwb_hit = memwb_reg_write && (memwb_rd_addr == addr) && (addr != REG_ZERO);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    sel  = FWD_NONE;
    data = reg_data;
    if (exmem_hit) begin
      sel  = FWD_EXMEM;
      data = exmem_data;
    end else if (memwb_hit) begin
      sel  = FWD_MEMWB;
      data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control and combinational operand
// forwarding from the EX/MEM and MEM/WB result buses into the ALU inputs.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    id_valid_i,
  input  logic [ALU_OP_WIDTH-1:0] id_alu_operation_i,
  input  logic [DATA_WIDTH-1:0]   id_rs_data_i,
  input  logic [DATA_WIDTH-1:0]   id_rt_data_i,
  input  logic [DATA_WIDTH-1:0]   id_imm_i,
  input  logic [4:0]              id_shamt_i,
  input  logic                    id_alu_src_i,
  input  logic [4:0]              id_rs_addr_i,
  input  logic [4:0]              id_rt_addr_i,
  input  logic [4:0]              id_rd_addr_i,
  input  logic                    id_reg_write_i,
  input  logic                    exmem_reg_write_i,
  input  logic [4:0]              exmem_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]   exmem_data_i,
  input  logic                    memwb_reg_write_i,
  input  logic [4:0]              memwb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]   memwb_data_i,
  output logic                    ex_valid_o,
  output logic [ALU_OP_WIDTH-1:0] alu_operation_o,
  output logic [DATA_WIDTH-1:0]   a_o,
  output logic [DATA_WIDTH-1:0]   b_o,
  output logic [4:0]              shamt_o,
  output logic [DATA_WIDTH-1:0]   ex_rt_data_o,
  output logic [4:0]              ex_rd_addr_o,
  output logic                    ex_reg_write_o
);

  typedef struct packed {
    logic                    valid;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]   rs_data;
    logic [DATA_WIDTH-1:0]   rt_data;
    logic [DATA_WIDTH-1:0]   imm;
    logic [4:0]              shamt;
    logic                    alu_src;
    logic [4:0]              rs_addr;
    logic [4:0]              rt_addr;
    logic [4:0]              rd_addr;
    logic                    reg_write;
  } slot_t;

  slot_t slot_d;
  slot_t slot_q;

  // An all-zero slot is the bubble: invalid, ALU_NOP, no write, addr $zero.
  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d = '0;
    end else if (!stall_i) begin
      slot_d = '{
        valid:     id_valid_i,
        alu_op:    id_alu_operation_i,
        rs_data:   id_rs_data_i,
        rt_data:   id_rt_data_i,
        imm:       id_imm_i,
        shamt:     id_shamt_i,
        alu_src:   id_alu_src_i,
        rs_addr:   id_rs_addr_i,
        rt_addr:   id_rt_addr_i,
        rd_addr:   id_rd_addr_i,
        reg_write: id_reg_write_i
      };
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  logic [DATA_WIDTH-1:0] rs_fwd;
  logic [DATA_WIDTH-1:0] rt_fwd;
  fwd_sel_e              unused_rs_sel;
  fwd_sel_e              unused_rt_sel;

  // The select outputs are only kept for waveform visibility of hazards.
  forward_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs (
    .addr            (slot_q.rs_addr),
    .reg_data        (slot_q.rs_data),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_rd_addr   (exmem_rd_addr_i),
    .exmem_data      (exmem_data_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_rd_addr   (memwb_rd_addr_i),
    .memwb_data      (memwb_data_i),
    .data            (rs_fwd),
    .sel             (unused_rs_sel)
  );

  forward_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rt (
    .addr            (slot_q.rt_addr),
    .reg_data        (slot_q.rt_data),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_rd_addr   (exmem_rd_addr_i),
    .exmem_data      (exmem_data_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_rd_addr   (memwb_rd_addr_i),
    .memwb_data      (memwb_data_i),
    .data            (rt_fwd),
    .sel             (unused_rt_sel)
  );

  assign ex_valid_o      = slot_q.valid;
  assign alu_operation_o = slot_q.alu_op;
  assign shamt_o         = slot_q.shamt;
  assign ex_rd_addr_o    = slot_q.rd_addr;
  assign ex_reg_write_o  = slot_q.reg_write & slot_q.valid;
  assign a_o             = rs_fwd;
  assign ex_rt_data_o    = rt_fwd;
  assign b_o             = slot_q.alu_src ? slot_q.imm : rt_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: expected EX-slot contents are
// queued as each step is driven and compared when the outputs settle.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic [3:0]  id_alu_operation_i = '0;
  logic [31:0] id_rs_data_i = '0, id_rt_data_i = '0, id_imm_i = '0;
  logic [4:0]  id_shamt_i = '0, id_rs_addr_i = '0, id_rt_addr_i = '0, id_rd_addr_i = '0;
  logic        id_alu_src_i = 1'b0, id_reg_write_i = 1'b0;
  logic        exmem_reg_write_i = 1'b0, memwb_reg_write_i = 1'b0;
  logic [4:0]  exmem_rd_addr_i = '0, memwb_rd_addr_i = '0;
  logic [31:0] exmem_data_i = '0, memwb_data_i = '0;
  logic        ex_valid_o, ex_reg_write_o;
  logic [3:0]  alu_operation_o;
  logic [31:0] a_o, b_o, ex_rt_data_o;
  logic [4:0]  shamt_o, ex_rd_addr_o;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_alu_operation_i(id_alu_operation_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_shamt_i(id_shamt_i), .id_alu_src_i(id_alu_src_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_reg_write_i(id_reg_write_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_addr_i(exmem_rd_addr_i),
    .exmem_data_i(exmem_data_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_addr_i(memwb_rd_addr_i),
    .memwb_data_i(memwb_data_i),
    .ex_valid_o(ex_valid_o), .alu_operation_o(alu_operation_o), .a_o(a_o), .b_o(b_o),
    .shamt_o(shamt_o), .ex_rt_data_o(ex_rt_data_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_reg_write_o(ex_reg_write_o)
  );

  typedef struct {
    string       tag;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a, b, rt;
    logic [4:0]  shamt, rd;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive_id(input logic v, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] imm, input logic [4:0] sh,
                          input logic src, input logic [4:0] rs_a, input logic [4:0] rt_a,
                          input logic [4:0] rd_a, input logic rw);
    id_valid_i = v; id_alu_operation_i = op; id_rs_data_i = rs; id_rt_data_i = rt;
    id_imm_i = imm; id_shamt_i = sh; id_alu_src_i = src; id_rs_addr_i = rs_a;
    id_rt_addr_i = rt_a; id_rd_addr_i = rd_a; id_reg_write_i = rw;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    exmem_reg_write_i = ew; exmem_rd_addr_i = erd; exmem_data_i = ed;
    memwb_reg_write_i = mw; memwb_rd_addr_i = mrd; memwb_data_i = md;
  endtask

  task automatic push_exp(input string tag, input logic v, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] rt,
                          input logic [4:0] sh, input logic [4:0] rd, input logic rw);
    exp_t e;
    e.tag = tag; e.valid = v; e.op = op; e.a = a; e.b = b; e.rt = rt;
    e.shamt = sh; e.rd = rd; e.rw = rw;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks_total++;
      $error("FAIL sb_underflow: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".valid"}, 32'(ex_valid_o),      32'(e.valid));
      check({e.tag, ".op"},    32'(alu_operation_o), 32'(e.op));
      check({e.tag, ".a"},     a_o,                  e.a);
      check({e.tag, ".b"},     b_o,                  e.b);
      check({e.tag, ".rt"},    ex_rt_data_o,         e.rt);
      check({e.tag, ".shamt"}, 32'(shamt_o),         32'(e.shamt));
      check({e.tag, ".rd"},    32'(ex_rd_addr_o),    32'(e.rd));
      check({e.tag, ".rw"},    32'(ex_reg_write_o),  32'(e.rw));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held across edges, then released away from an edge.
    push_exp("in_reset", 0, 4'h0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    pop_check();
    #2 reset = 1'b1;
    push_exp("post_reset_idle", 0, 4'h0, 0, 0, 0, 0, 0, 0);
    tick();
    pop_check();

    // ADD with no hazards.
    drive_id(1, ALU_ADD, 32'h5, 32'hA, 32'h0, 5'd7, 0, 5'd1, 5'd2, 5'd3, 1);
    push_exp("add_basic", 1, 4'h3, 32'h5, 32'hA, 32'hA, 5'd7, 5'd3, 1);
    tick();
    pop_check();

    // EX/MEM and MEM/WB both target rs=8: EX/MEM wins, then MEM/WB after drop.
    drive_id(1, ALU_SUB, 32'h100, 32'h200, 32'h0, 5'd0, 0, 5'd8, 5'd9, 5'd4, 1);
    set_fwd(1, 5'd8, 32'h11, 1, 5'd8, 32'h22);
    push_exp("fwd_exmem_prio", 1, 4'h1, 32'h11, 32'h200, 32'h200, 0, 5'd4, 1);
    tick();
    pop_check();
    exmem_reg_write_i = 1'b0;
    push_exp("fwd_memwb", 1, 4'h1, 32'h22, 32'h200, 32'h200, 0, 5'd4, 1);
    #1 pop_check();

    // Register 0 is never forwarded, even with a pending write to it.
    drive_id(1, ALU_OR, 32'h44, 32'h33, 32'h0, 5'd0, 0, 5'd0, 5'd0, 5'd5, 1);
    set_fwd(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hEEEE_EEEE);
    push_exp("reg_zero", 1, 4'h2, 32'h44, 32'h33, 32'h33, 0, 5'd5, 1);
    tick();
    pop_check();

    // Immediate operand selected while rt is forwarded to store data.
    drive_id(1, ALU_LUI, 32'h66, 32'h55, 32'h0000_1234, 5'd2, 1, 5'd6, 5'd5, 5'd7, 1);
    set_fwd(1, 5'd5, 32'hBEEF, 0, 5'd0, 32'h0);
    push_exp("imm_src", 1, 4'h4, 32'h66, 32'h1234, 32'hBEEF, 5'd2, 5'd7, 1);
    tick();
    pop_check();

    // Stall three edges while decode changes; slot must hold.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1, ALU_SLL, 32'($urandom), 32'($urandom), 32'($urandom), 5'd31, 0,
               5'd12, 5'd13, 5'd14, 0);
      push_exp($sformatf("stall_%0d", i), 1, 4'h4, 32'h66, 32'h1234, 32'hBEEF, 5'd2, 5'd7, 1);
      tick();
      pop_check();
    end
    // Forwarding keeps tracking live buses while stalled.
    set_fwd(1, 5'd6, 32'hCAFE, 1, 5'd5, 32'h5A5A);
    push_exp("stall_live_fwd", 1, 4'h4, 32'hCAFE, 32'h1234, 32'h5A5A, 5'd2, 5'd7, 1);
    #1 pop_check();

    // Flush overrides stall.
    flush_i = 1'b1;
    push_exp("flush_over_stall", 0, 4'h0, 0, 0, 0, 0, 0, 0);
    tick();
    pop_check();
    flush_i = 1'b0;
    stall_i = 1'b0;

    // Invalid slot with reg_write set: write enable is qualified by valid.
    drive_id(0, ALU_ADD, 32'h1, 32'h2, 32'h0, 5'd0, 0, 5'd3, 5'd4, 5'd9, 1);
    set_fwd(0, 5'd0, 32'h0, 1, 5'd4, 32'h77);
    push_exp("rw_qualified", 0, 4'h3, 32'h1, 32'h77, 32'h77, 0, 5'd9, 0);
    tick();
    pop_check();

    // Asynchronous reset during a stall empties the slot without a clock edge.
    drive_id(1, ALU_ADD, 32'h9, 32'h8, 32'h0, 5'd3, 0, 5'd10, 5'd11, 5'd12, 1);
    set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    push_exp("pre_async_reset", 1, 4'h3, 32'h9, 32'h8, 32'h8, 5'd3, 5'd12, 1);
    tick();
    pop_check();
    stall_i = 1'b1;
    #2 reset = 1'b0;
    push_exp("async_reset", 0, 4'h0, 0, 0, 0, 0, 0, 0);
    #1 pop_check();
    tick();
    #2 reset = 1'b1;
    stall_i = 1'b0;

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
